// File: rtl/vscale_hasti_sram_if.sv
// HASTI (AHB-Lite subset) bus bundle between one master and the SRAM slave.
interface vscale_hasti_sram_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock,
        output hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock,
        input  hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_sram.sv
// Word-organised HASTI SRAM slave with byte lanes, optional data-phase
// wait states and a two-cycle ERROR response for illegal transfers.
module vscale_hasti_sram #(
    parameter int NWORDS      = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic                 clk,
    input logic                 reset_n,
    vscale_hasti_sram_if.slave  bus
);
    localparam int          AW        = $clog2(NWORDS);
    localparam logic [31:0] MEM_BYTES = 32'(NWORDS) << 2;
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            hready_q, hready_d;
    logic            hresp_q, hresp_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;

    logic [31:0]     mem [NWORDS];
    logic            accept;
    logic            illegal;
    logic            we;
    logic [3:0]      be;
    logic            unused_ok;

    assign accept  = hready_q && bus.htrans[1];
    assign illegal = (bus.hsize > 3'd2)
                  || (bus.hsize == 3'd1 && bus.haddr[0])
                  || (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00)
                  || (bus.haddr >= MEM_BYTES);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        if (accept) begin
            idx_d   = bus.haddr[AW+1:2];
            off_d   = bus.haddr[1:0];
            size_d  = bus.hsize[1:0];
            write_d = bus.hwrite;
        end
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_DATA;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                cnt_d = 3'd0;
                if (!accept) begin
                    state_d = S_IDLE;
                end else if (illegal) begin
                    state_d = S_ERR1;
                end else if (WS != 3'd0) begin
                    state_d = S_WAIT;
                    cnt_d   = WS;
                end else begin
                    state_d = S_DATA;
                end
            end
        endcase
        // Outputs are registered: derived from the state being entered.
        hready_d = state_d inside {S_IDLE, S_DATA, S_ERR2};
        hresp_d  = state_d inside {S_ERR1, S_ERR2};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            idx_q    <= '0;
            off_q    <= 2'b00;
            size_q   <= 2'b00;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        be = 4'b0000;
        unique case (1'b1)
            size_q == 2'd0: be = 4'b0001 << off_q;
            size_q == 2'd1: be = off_q[1] ? 4'b1100 : 4'b0011;
            default:        be = 4'b1111;
        endcase
    end

    assign we = (state_q == S_DATA) && write_q;

    // Array is never reset; a write that reset aborts never reaches DATA.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    assign bus.hrdata = (state_q == S_DATA && !write_q) ? mem[idx_q] : 32'h0;
    assign bus.hready = hready_q;
    assign bus.hresp  = hresp_q;

    assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot, bus.htrans[0]};
endmodule

// File: tb/tb_vscale_hasti_sram.sv
// Directed and random bench for vscale_hasti_sram with zero and two
// wait states, driven by a small pipelined master and byte-array model.
module tb_vscale_hasti_sram;
    localparam int NW = 64;

    typedef struct {
        logic [31:0] addr;
        logic        w;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic        err;
    } op_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] hr_trace;
    int          hr_cyc;
    logic [31:0] last_rd;
    logic [7:0]  mdl [2][256];
    op_t         ops [$];

    always #5 clk = ~clk;

    vscale_hasti_sram_if b0();
    vscale_hasti_sram_if b2();

    assign b0.haddr     = haddr;
    assign b0.hwrite    = hwrite;
    assign b0.hsize     = hsize;
    assign b0.hburst    = 3'b000;
    assign b0.hmastlock = 1'b0;
    assign b0.hprot     = 4'b0011;
    assign b0.htrans    = sel ? 2'b00 : htrans;
    assign b0.hwdata    = hwdata;
    assign b2.haddr     = haddr;
    assign b2.hwrite    = hwrite;
    assign b2.hsize     = hsize;
    assign b2.hburst    = 3'b000;
    assign b2.hmastlock = 1'b0;
    assign b2.hprot     = 4'b0011;
    assign b2.htrans    = sel ? htrans : 2'b00;
    assign b2.hwdata    = hwdata;

    assign hready = sel ? b2.hready : b0.hready;
    assign hresp  = sel ? b2.hresp  : b0.hresp;
    assign hrdata = sel ? b2.hrdata : b0.hrdata;

    vscale_hasti_sram #(.NWORDS(NW), .WAIT_STATES(0)) u_ws0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    vscale_hasti_sram #(.NWORDS(NW), .WAIT_STATES(2)) u_ws2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        if (a >= 32'(NW * 4)) return 1'b0;
        return (a % (32'd1 << s)) == 32'd0;
    endfunction

    function automatic logic [31:0] mword(input int s, input logic [31:0] a);
        int b;
        b = int'(a & 32'h0000_00FC);
        return {mdl[s][b+3], mdl[s][b+2], mdl[s][b+1], mdl[s][b]};
    endfunction

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [1:0] t, input logic [31:0] d);
        op_t o;
        o.addr  = a;
        o.w     = w;
        o.size  = s;
        o.trans = t;
        o.wdata = d;
        o.err   = !legal(a, s);
        ops.push_back(o);
    endtask

    task automatic drive_idle();
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd2;
        htrans = 2'b00;
    endtask

    task automatic drive_op(input op_t o);
        haddr  = o.addr;
        hwrite = o.w;
        hsize  = o.size;
        htrans = o.trans;
    endtask

    // Called at a negedge; each iteration inspects the upcoming edge.
    task automatic run_ops(input bit junk);
        int   idx;
        int   n;
        int   s;
        bit   dv;
        op_t  dp;
        idx      = 0;
        n        = ops.size();
        dv       = 1'b0;
        s        = sel ? 1 : 0;
        hr_trace = 32'h0;
        hr_cyc   = 0;
        for (int c = 0; c < 40 * n + 40 && (idx < n || dv); c++) begin
            hwdata   = dv ? dp.wdata : 32'h0;
            hr_trace = {hr_trace[30:0], hready};
            hr_cyc++;
            if (dv) begin
                check($sformatf("resp@%h", dp.addr), {31'b0, hresp},
                      {31'b0, dp.err});
                if (!hready || dp.err) begin
                    check($sformatf("zero@%h", dp.addr), hrdata, 32'h0);
                end else if (!dp.w) begin
                    check($sformatf("rd@%h", dp.addr), hrdata,
                          mword(s, dp.addr));
                    last_rd = hrdata;
                end
                if (hready) begin
                    if (dp.w && !dp.err) begin
                        for (int k = 0; k < (1 << dp.size); k++) begin
                            int p;
                            p = int'(dp.addr) + k;
                            mdl[s][p] = dp.wdata[8*(p%4) +: 8];
                        end
                    end
                    dv = 1'b0;
                end
            end else begin
                check("idle_hready", {31'b0, hready}, 32'h1);
                check("idle_out", {31'b0, hresp} | hrdata, 32'h0);
            end
            if (hready) begin
                if (idx < n) begin
                    drive_op(ops[idx]);
                    if (ops[idx].trans[1]) begin
                        dp = ops[idx];
                        dv = 1'b1;
                    end
                    idx++;
                end else begin
                    drive_idle();
                end
            end else if (junk) begin
                haddr  = $urandom;
                hwrite = 1'($urandom);
                hsize  = 3'($urandom);
                htrans = 2'($urandom);
            end else if (idx < n) begin
                drive_op(ops[idx]);
            end else begin
                drive_idle();
            end
            @(negedge clk);
        end
        if (idx < n || dv) check("timeout", 32'h1, 32'h0);
        drive_idle();
        ops.delete();
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int          u;
        reset_n = 1'b0;
        sel     = 1'b0;
        hwdata  = 32'h0;
        last_rd = 32'h0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_hready0", {31'b0, b0.hready}, 32'h1);
        check("rst_hresp0", {31'b0, b0.hresp}, 32'h0);
        check("rst_hrdata0", b0.hrdata, 32'h0);
        check("rst_hready2", {31'b0, b2.hready}, 32'h1);
        reset_n = 1'b1;

        add(32'h10, 1'b1, 3'd2, 2'b10, 32'hDEADBEEF);
        add(32'h10, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("b2b_rd", last_rd, 32'hDEADBEEF);
        check("b2b_trace", hr_trace, 32'h7);
        check("b2b_cyc", 32'(hr_cyc), 32'd3);

        add(32'h10, 1'b1, 3'd2, 2'b10, 32'h0);
        add(32'h11, 1'b1, 3'd0, 2'b10, 32'h0000AA00);
        add(32'h12, 1'b1, 3'd1, 2'b11, 32'h55550000);
        add(32'h10, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("lanes_rd", last_rd, 32'h5555AA00);
        check("lanes_trace", hr_trace, 32'h1F);

        add(32'h00, 1'b1, 3'd2, 2'b10, 32'h0BADF00D);
        run_ops(1'b0);
        add(32'h02, 1'b0, 3'd2, 2'b10, 32'h0);
        add(32'h00, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("err_trace", hr_trace, 32'hB);
        check("err_cyc", 32'(hr_cyc), 32'd4);
        add(32'(NW * 4), 1'b1, 3'd2, 2'b10, 32'hFFFFFFFF);
        add(32'h01, 1'b1, 3'd1, 2'b10, 32'hFFFFFFFF);
        add(32'h00, 1'b1, 3'd3, 2'b10, 32'hFFFFFFFF);
        add(32'h00, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("err_nowrite", last_rd, 32'h0BADF00D);

        sel = 1'b1;
        add(32'h40, 1'b1, 3'd2, 2'b10, 32'h01234567);
        add(32'h44, 1'b1, 3'd2, 2'b10, 32'h89ABCDEF);
        run_ops(1'b0);
        add(32'h40, 1'b0, 3'd2, 2'b10, 32'h0);
        add(32'h44, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("ws_trace", hr_trace, 32'h49);
        check("ws_cyc", 32'(hr_cyc), 32'd7);
        check("ws_rd", last_rd, 32'h89ABCDEF);
        add(32'h48, 1'b1, 3'd2, 2'b10, 32'hA5A5A5A5);
        add(32'h48, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("ws_raw", last_rd, 32'hA5A5A5A5);

        add(32'h20, 1'b1, 3'd2, 2'b10, 32'h11223344);
        run_ops(1'b0);
        haddr  = 32'h20;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = 2'b10;
        @(negedge clk);
        htrans = 2'b00;
        hwdata = 32'hCAFEF00D;
        check("rst_wait_hready", {31'b0, hready}, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_hready", {31'b0, hready}, 32'h1);
        check("arst_hresp", {31'b0, hresp}, 32'h0);
        check("arst_hrdata", hrdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        add(32'h20, 1'b0, 3'd2, 2'b10, 32'h0);
        run_ops(1'b0);
        check("rst_discard", last_rd, 32'h11223344);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 16; w++) add(32'(w * 4), 1'b1, 3'd2, 2'b10, $urandom);
            run_ops(1'b0);
            for (int i = 0; i < 150; i++) begin
                u = $urandom_range(0, 9);
                a = (u == 0) ? 32'(NW * 4) + $urandom_range(0, 255)
                  : (u == 1) ? $urandom : 32'($urandom_range(0, 63));
                sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                u = $urandom_range(0, 9);
                tr = (u < 4) ? 2'b10 : (u < 6) ? 2'b11 : (u < 8) ? 2'b00 : 2'b01;
                add(a, 1'($urandom), sz, tr, $urandom);
            end
            run_ops(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
